// File: rtl/vicii_video_pkg.sv
// Shared types and default raster timing for the VIC-II composite video path.
// Optional PAL line alternation is selected with the VICII_PAL_ALT_EN macro.
package vicii_video_pkg;

    localparam int LUMA_W   = 5;
    localparam int CHROMA_W = 5;
    localparam int CNT_W    = 9;

    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [LUMA_W-1:0]   luma_t;
    typedef logic [CHROMA_W-1:0] chroma_t;

    typedef enum logic [2:0] {
        SEG_SYNC,
        SEG_VSYNC_BROAD,
        SEG_BURST,
        SEG_ACTIVE,
        SEG_PORCH
    } segment_t;

    localparam cnt_t    DEF_LINE_CYCLES  = 9'd504;
    localparam cnt_t    DEF_FRAME_LINES  = 9'd312;
    localparam cnt_t    DEF_SYNC_LEN     = 9'd38;
    localparam cnt_t    DEF_BURST_START  = 9'd44;
    localparam cnt_t    DEF_BURST_LEN    = 9'd18;
    localparam cnt_t    DEF_ACTIVE_START = 9'd92;
    localparam cnt_t    DEF_ACTIVE_LEN   = 9'd403;
    localparam cnt_t    DEF_VSYNC_LINES  = 9'd3;
    localparam cnt_t    DEF_VBLANK_LINES = 9'd16;
    localparam chroma_t DEF_BURST_PHASE  = 5'd12;

    // Phase reflection on the 32-step colour wheel: (32 - c) mod 32.
    function automatic chroma_t chroma_flip(input chroma_t c);
        return 5'd0 - c;
    endfunction

endpackage

// File: rtl/vicii_raster_counter.sv
// Horizontal/vertical raster counters with an odd-line flag and a frame-wrap flag.
module vicii_raster_counter
    import vicii_video_pkg::*;
#(
    parameter cnt_t LINE_CYCLES = DEF_LINE_CYCLES,
    parameter cnt_t FRAME_LINES = DEF_FRAME_LINES
) (
    input  logic clk,
    input  logic rst,
    output cnt_t hcnt,
    output cnt_t vcnt,
    output logic odd,
    output logic frame_wrap
);

    logic line_wrap;

    assign line_wrap  = (hcnt == LINE_CYCLES - 9'd1);
    assign frame_wrap = line_wrap && (vcnt == FRAME_LINES - 9'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
            odd  <= 1'b0;
        end else if (line_wrap) begin
            hcnt <= '0;
            odd  <= ~odd;
            vcnt <= frame_wrap ? '0 : vcnt + 9'd1;
        end else begin
            hcnt <= hcnt + 9'd1;
        end
    end

endmodule

// File: rtl/vicii_video_sequencer.sv
// Raster sequencer: decodes sync/burst/active/porch segments and registers the DAC stream.
// Define VICII_PAL_ALT_EN to reflect burst and active chroma phase on odd lines.
module vicii_video_sequencer
    import vicii_video_pkg::*;
#(
    parameter cnt_t    LINE_CYCLES  = DEF_LINE_CYCLES,
    parameter cnt_t    FRAME_LINES  = DEF_FRAME_LINES,
    parameter cnt_t    SYNC_LEN     = DEF_SYNC_LEN,
    parameter cnt_t    BURST_START  = DEF_BURST_START,
    parameter cnt_t    BURST_LEN    = DEF_BURST_LEN,
    parameter cnt_t    ACTIVE_START = DEF_ACTIVE_START,
    parameter cnt_t    ACTIVE_LEN   = DEF_ACTIVE_LEN,
    parameter cnt_t    VSYNC_LINES  = DEF_VSYNC_LINES,
    parameter cnt_t    VBLANK_LINES = DEF_VBLANK_LINES,
    parameter chroma_t BURST_PHASE  = DEF_BURST_PHASE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    pix_luma,
    input  logic [4:0]    pix_chroma,
    input  logic          pix_chroma_en,
    output logic          pix_req,
    output logic [4:0]    luma,
    output logic [4:0]    chroma,
    output logic          chroma_en,
    output logic          sync_n,
    output logic          burst,
    output logic          blank,
    output logic [8:0]    hpos,
    output logic [8:0]    vpos,
    output logic          frame_start
);

`ifdef VICII_PAL_ALT_EN
    localparam bit PAL_ALT = 1'b1;
`else
    localparam bit PAL_ALT = 1'b0;
`endif

    cnt_t     hcnt;
    cnt_t     vcnt;
    logic     odd;
    logic     frame_wrap;
    logic     at_origin;
    logic     alt_line;
    segment_t seg;
    chroma_t  burst_phase;

    luma_t    n_luma;
    chroma_t  n_chroma;
    logic     n_chroma_en;
    logic     n_sync_n;
    logic     n_burst;
    logic     n_blank;

    vicii_raster_counter #(
        .LINE_CYCLES (LINE_CYCLES),
        .FRAME_LINES (FRAME_LINES)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .odd        (odd),
        .frame_wrap (frame_wrap)
    );

    always_comb begin
        seg = SEG_PORCH;
        if (vcnt < VSYNC_LINES) begin
            if (hcnt < LINE_CYCLES - SYNC_LEN)
                seg = SEG_VSYNC_BROAD;
        end else if (hcnt < SYNC_LEN) begin
            seg = SEG_SYNC;
        end else if (vcnt >= VBLANK_LINES) begin
            if (hcnt >= BURST_START && hcnt < BURST_START + BURST_LEN)
                seg = SEG_BURST;
            else if (hcnt >= ACTIVE_START && hcnt < ACTIVE_START + ACTIVE_LEN)
                seg = SEG_ACTIVE;
        end
    end

    // Handshake: pix_req is a same-cycle request with no backpressure; upstream must
    // present pix_luma/pix_chroma/pix_chroma_en in every cycle pix_req is high.
    assign pix_req = (seg == SEG_ACTIVE) && !rst;

    assign alt_line    = PAL_ALT && odd;
    assign burst_phase = alt_line ? chroma_flip(BURST_PHASE) : BURST_PHASE;

    always_comb begin
        n_luma      = '0;
        n_chroma    = '0;
        n_chroma_en = 1'b0;
        n_sync_n    = 1'b1;
        n_burst     = 1'b0;
        n_blank     = 1'b1;
        case (seg)
            SEG_SYNC, SEG_VSYNC_BROAD: n_sync_n = 1'b0;
            SEG_BURST: begin
                n_chroma_en = 1'b1;
                n_chroma    = burst_phase;
                n_burst     = 1'b1;
            end
            SEG_ACTIVE: begin
                n_luma      = pix_luma;
                n_chroma_en = pix_chroma_en;
                n_chroma    = pix_chroma_en ?
                              (alt_line ? chroma_flip(pix_chroma) : pix_chroma) : '0;
                n_blank     = 1'b0;
            end
            default: ;
        endcase
    end

    // at_origin marks the cycle in which the counters sit at (0,0): after reset or a frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin   <= 1'b1;
            luma        <= '0;
            chroma      <= '0;
            chroma_en   <= 1'b0;
            sync_n      <= 1'b1;
            burst       <= 1'b0;
            blank       <= 1'b1;
            hpos        <= '0;
            vpos        <= '0;
            frame_start <= 1'b0;
        end else begin
            at_origin   <= frame_wrap;
            luma        <= n_luma;
            chroma      <= n_chroma;
            chroma_en   <= n_chroma_en;
            sync_n      <= n_sync_n;
            burst       <= n_burst;
            blank       <= n_blank;
            hpos        <= hcnt;
            vpos        <= vcnt;
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_vicii_video_sequencer.sv
// Directed bench for vicii_video_sequencer; frame shortened to 24 lines to keep runs short.
module tb_vicii_video_sequencer;

    localparam int LINE     = 504;
    localparam int TB_LINES = 24;
`ifdef VICII_PAL_ALT_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] pix_luma;
    logic [4:0] pix_chroma;
    logic       pix_chroma_en;
    logic       pix_req;
    logic [4:0] luma;
    logic [4:0] chroma;
    logic       chroma_en;
    logic       sync_n;
    logic       burst;
    logic       blank;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;
    int h = 0;
    int v = 0;

    int n_sync, n_burst, first_burst, burst_chroma, burst_en;
    int first_active, n_active, act_chroma, act_luma, act_en;
    int n_req, n_fs, n_bad_pos, n_luma_blank, n_chroma_noen;
    int sum_sync, sum_burst, sum_req, sum_active, sum_bad;

    vicii_video_sequencer #(
        .FRAME_LINES (9'd24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_luma      (pix_luma),
        .pix_chroma    (pix_chroma),
        .pix_chroma_en (pix_chroma_en),
        .pix_req       (pix_req),
        .luma          (luma),
        .chroma        (chroma),
        .chroma_en     (chroma_en),
        .sync_n        (sync_n),
        .burst         (burst),
        .blank         (blank),
        .hpos          (hpos),
        .vpos          (vpos),
        .frame_start   (frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; h/v track the expected hpos/vpos.
    task automatic step();
        @(posedge clk);
        #1;
        h++;
        if (h == LINE) begin
            h = 0;
            v = (v == TB_LINES - 1) ? 0 : v + 1;
        end
    endtask

    // Collects statistics over one full output line starting at hpos=0.
    task automatic run_line();
        n_sync = 0; n_burst = 0; first_burst = -1; burst_chroma = -1; burst_en = -1;
        first_active = -1; n_active = 0; act_chroma = -1; act_luma = -1; act_en = -1;
        n_req = 0; n_fs = 0; n_bad_pos = 0; n_luma_blank = 0; n_chroma_noen = 0;
        repeat (LINE) begin
            if (hpos !== 9'(h) || vpos !== 9'(v)) n_bad_pos++;
            if (sync_n === 1'b0) n_sync++;
            if (burst === 1'b1) begin
                if (first_burst < 0) begin
                    first_burst  = int'(hpos);
                    burst_chroma = int'(chroma);
                    burst_en     = int'(chroma_en);
                end
                n_burst++;
            end
            if (blank === 1'b0) begin
                if (first_active < 0) begin
                    first_active = int'(hpos);
                    act_chroma   = int'(chroma);
                    act_luma     = int'(luma);
                    act_en       = int'(chroma_en);
                end
                n_active++;
            end else if (luma !== 5'd0) begin
                n_luma_blank++;
            end
            if (chroma_en !== 1'b1 && chroma !== 5'd0) n_chroma_noen++;
            if (pix_req === 1'b1) n_req++;
            if (frame_start === 1'b1) n_fs++;
            step();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_luma"},        32'(luma),        32'd0);
        check({pfx, "_chroma"},      32'(chroma),      32'd0);
        check({pfx, "_chroma_en"},   32'(chroma_en),   32'd0);
        check({pfx, "_sync_n"},      32'(sync_n),      32'd1);
        check({pfx, "_burst"},       32'(burst),       32'd0);
        check({pfx, "_blank"},       32'(blank),       32'd1);
        check({pfx, "_pix_req"},     32'(pix_req),     32'd0);
        check({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
        check({pfx, "_hpos"},        32'(hpos),        32'd0);
        check({pfx, "_vpos"},        32'(vpos),        32'd0);
    endtask

    initial begin
        int guard;
        rst           = 1'b1;
        pix_luma      = 5'd10;
        pix_chroma    = 5'd5;
        pix_chroma_en = 1'b1;

        repeat (5) step();
        check_reset_outputs("rst");

        rst = 1'b0;
        step();
        h = 0; v = 0;
        check("post_rst_hpos",  32'(hpos),        32'd0);
        check("post_rst_vpos",  32'(vpos),        32'd0);
        check("post_rst_fs",    32'(frame_start), 32'd1);
        check("post_rst_sync",  32'(sync_n),      32'd0);

        // lines 0..2: broad vsync
        run_line();
        check("l0_sync_len", n_sync,    466);
        check("l0_burst",    n_burst,   0);
        check("l0_req",      n_req,     0);
        check("l0_fs_count", n_fs,      1);
        check("l0_pos",      n_bad_pos, 0);
        for (int l = 1; l < 3; l++) begin
            run_line();
            check("vs_sync_len", n_sync,  466);
            check("vs_burst",    n_burst, 0);
        end

        // lines 3..15: blanked, normal hsync only
        sum_sync = 0; sum_burst = 0; sum_req = 0; sum_active = 0; sum_bad = 0;
        for (int l = 3; l < 16; l++) begin
            run_line();
            sum_sync += n_sync; sum_burst += n_burst; sum_req += n_req;
            sum_active += n_active; sum_bad += n_bad_pos;
        end
        check("vb_sync_total",   sum_sync,   494);
        check("vb_burst_total",  sum_burst,  0);
        check("vb_req_total",    sum_req,    0);
        check("vb_active_total", sum_active, 0);
        check("vb_pos",          sum_bad,    0);

        // lines 16..19: visible
        sum_req = 0; sum_bad = 0;
        for (int l = 16; l < 20; l++) begin
            run_line();
            sum_req += n_req; sum_bad += n_bad_pos;
        end
        check("vis_req_total", sum_req, 1612);
        check("vis_pos",       sum_bad, 0);

        // line 20 (even)
        run_line();
        check("l20_sync_len",     n_sync,        38);
        check("l20_burst_len",    n_burst,       18);
        check("l20_burst_start",  first_burst,   44);
        check("l20_burst_chroma", burst_chroma,  12);
        check("l20_burst_en",     burst_en,      1);
        check("l20_active_start", first_active,  92);
        check("l20_active_len",   n_active,      403);
        check("l20_req",          n_req,         403);
        check("l20_act_chroma",   act_chroma,    5);
        check("l20_act_luma",     act_luma,      10);
        check("l20_act_en",       act_en,        1);
        check("l20_luma_blank",   n_luma_blank,  0);
        check("l20_chroma_noen",  n_chroma_noen, 0);

        // line 21 (odd)
        run_line();
        check("l21_burst_chroma", burst_chroma, ALT ? 20 : 12);
        check("l21_act_chroma",   act_chroma,   ALT ? 27 : 5);
        check("l21_act_luma",     act_luma,     10);
        check("l21_active_len",   n_active,     403);

        // line 22: chroma disabled upstream, chroma must be forced to 0
        pix_chroma_en = 1'b0;
        pix_luma      = 5'd31;
        run_line();
        check("l22_act_en",       act_en,        0);
        check("l22_act_chroma",   act_chroma,    0);
        check("l22_act_luma",     act_luma,      31);
        check("l22_chroma_noen",  n_chroma_noen, 0);
        check("l22_burst_chroma", burst_chroma,  12);
        check("l22_burst_len",    n_burst,       18);
        pix_chroma_en = 1'b1;
        pix_luma      = 5'd10;

        // last line of frame and the wrap
        repeat (503) step();
        check("eof_hpos", 32'(hpos), 32'd503);
        check("eof_vpos", 32'(vpos), 32'd23);
        step();
        check("wrap_hpos", 32'(hpos),        32'd0);
        check("wrap_vpos", 32'(vpos),        32'd0);
        check("wrap_fs",   32'(frame_start), 32'd1);
        step();
        check("wrap_fs_once", 32'(frame_start), 32'd0);

        // reset in the middle of an active line
        guard = 0;
        while (!(v == 16 && h == 200) && guard < 20000) begin
            step();
            guard++;
        end
        check("mid_reach",   guard < 20000 ? 1 : 0, 1);
        check("mid_pix_req", 32'(pix_req), 32'd1);
        check("mid_blank",   32'(blank),   32'd0);
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        step();
        rst = 1'b0;
        step();
        h = 0; v = 0;
        check("restart_hpos", 32'(hpos),        32'd0);
        check("restart_fs",   32'(frame_start), 32'd1);
        run_line();
        check("restart_sync_len", n_sync,    466);
        check("restart_fs_count", n_fs,      1);
        check("restart_pos",      n_bad_pos, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
